// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data memory port among cores (stats: DMEM_ARB_STATS_EN)
module dmem_arbiter #(
    parameter int num_req_p    = 4,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    localparam int owner_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [num_req_p-1:0]              req_valid_i,
    input  logic [num_req_p-1:0]              req_wen_i,
    input  logic [num_req_p-1:0]              req_byte_i,
    input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
    input  logic [num_req_p*data_width_p-1:0] req_wdata_i,
    output logic [num_req_p-1:0]              req_yumi_o,
    output logic [num_req_p-1:0]              resp_valid_o,
    output logic [data_width_p-1:0]           resp_data_o,
    input  logic [num_req_p-1:0]              req_yumi_i,
    output logic                              mem_valid_o,
    output logic                              mem_wen_o,
    output logic                              mem_byte_o,
    output logic [addr_width_p-1:0]           mem_addr_o,
    output logic [data_width_p-1:0]           mem_wdata_o,
    input  logic                              mem_yumi_i,
    input  logic                              mem_valid_i,
    input  logic [data_width_p-1:0]           mem_data_i,
    output logic                              mem_yumi_o,
    output logic [owner_width_lp-1:0]         owner_o
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [num_req_p*16-1:0]           grant_cnt_o,
    output logic [15:0]                       wait_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e                    state_r, state_n;
    logic [owner_width_lp-1:0] rr_ptr_r, owner_r, winner, next_ptr;
    logic [owner_width_lp:0]   scan_idx;
    logic                      any_valid;
    logic                      wen_r, byte_r;
    logic [addr_width_p-1:0]   addr_r;
    logic [data_width_p-1:0]   wdata_r;

    // Scan from rr_ptr upward with explicit wrap so non-power-of-two counts work.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        scan_idx  = '0;
        for (int i = 0; i < num_req_p; i++) begin
            scan_idx = {1'b0, rr_ptr_r} + (owner_width_lp+1)'(i);
            if (scan_idx >= (owner_width_lp+1)'(num_req_p))
                scan_idx = scan_idx - (owner_width_lp+1)'(num_req_p);
            if (!any_valid && req_valid_i[scan_idx[owner_width_lp-1:0]]) begin
                any_valid = 1'b1;
                winner    = scan_idx[owner_width_lp-1:0];
            end
        end
    end

    assign next_ptr = (winner == owner_width_lp'(num_req_p - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            owner_r  <= '0;
            wen_r    <= 1'b0;
            byte_r   <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == IDLE && any_valid) begin
                owner_r  <= winner;
                rr_ptr_r <= next_ptr;
                wen_r    <= req_wen_i[winner];
                byte_r   <= req_byte_i[winner];
                addr_r   <= req_addr_i[int'(winner)*addr_width_p +: addr_width_p];
                wdata_r  <= req_wdata_i[int'(winner)*data_width_p +: data_width_p];
            end
        end
    end

    // Every output is forced low while reset is asserted.
    always_comb begin
        state_n      = state_r;
        mem_valid_o  = 1'b0;
        mem_yumi_o   = 1'b0;
        resp_data_o  = '0;
        req_yumi_o   = '0;
        resp_valid_o = '0;
        case (state_r)
            IDLE: if (any_valid) state_n = REQ;
            REQ: begin
                mem_valid_o = reset;
                if (mem_yumi_i) state_n = RESP;
            end
            RESP: begin
                resp_data_o = reset ? mem_data_i : '0;
                mem_yumi_o  = reset & mem_valid_i & req_yumi_i[owner_r];
                if (mem_valid_i && req_yumi_i[owner_r]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        for (int i = 0; i < num_req_p; i++) begin
            req_yumi_o[i]   = reset && state_r == REQ && mem_yumi_i
                              && owner_r == owner_width_lp'(i);
            resp_valid_o[i] = reset && state_r == RESP && mem_valid_i
                              && owner_r == owner_width_lp'(i);
        end
    end

    assign mem_wen_o   = reset & wen_r;
    assign mem_byte_o  = reset & byte_r;
    assign mem_addr_o  = reset ? addr_r : '0;
    assign mem_wdata_o = reset ? wdata_r : '0;
    assign owner_o     = reset ? owner_r : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] grant_cnt_r [num_req_p];
    logic [15:0] wait_cnt_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < num_req_p; i++) grant_cnt_r[i] <= '0;
            wait_cnt_r <= '0;
        end else begin
            for (int i = 0; i < num_req_p; i++)
                if (state_r == IDLE && any_valid && winner == owner_width_lp'(i)
                    && grant_cnt_r[i] != 16'hFFFF)
                    grant_cnt_r[i] <= grant_cnt_r[i] + 16'd1;
            if (|req_valid_i && state_r != IDLE && wait_cnt_r != 16'hFFFF)
                wait_cnt_r <= wait_cnt_r + 16'd1;
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int i = 0; i < num_req_p; i++)
            grant_cnt_o[i*16 +: 16] = reset ? grant_cnt_r[i] : 16'd0;
    end
    assign wait_cnt_o = reset ? wait_cnt_r : 16'd0;
`endif

endmodule
